// File: rtl/lsru_cfg_seq_if.sv
// rtl/lsru_cfg_seq_if.sv - host/LSRU-facing signal bundle for lsru_cfg_seq (perf ports under LSRU_SEQ_PERF_EN)
interface lsru_cfg_seq_if #(
    parameter int CFG_BITS  = 24,
    parameter int AW        = 4,
    parameter int LOOP_BITS = 8
);
    logic                 Mode_in;
    logic                 Wr_en_in;
    logic [AW-1:0]        Wr_addr_in;
    logic [CFG_BITS-1:0]  Wr_data_in;
    logic                 Start_in;
    logic [AW-1:0]        Last_idx_in;
    logic [LOOP_BITS-1:0] Loop_cnt_in;
    logic                 Stall_in;
    logic                 Abort_in;

    logic                 En_out;
    logic                 Mode_out;
    logic                 Finish_out;
    logic [CFG_BITS-1:0]  CFG_out;
    logic                 Dvalid_out;
    logic                 Busy_out;
    logic                 Done_out;
    logic [AW-1:0]        Idx_out;
    logic [LOOP_BITS-1:0] Iter_out;
`ifdef LSRU_SEQ_PERF_EN
    logic [15:0]          Run_cyc_out;
    logic [15:0]          Stall_cyc_out;
`endif

    modport master (
        output Mode_in, Wr_en_in, Wr_addr_in, Wr_data_in, Start_in,
               Last_idx_in, Loop_cnt_in, Stall_in, Abort_in,
        input  En_out, Mode_out, Finish_out, CFG_out, Dvalid_out,
               Busy_out, Done_out, Idx_out, Iter_out
`ifdef LSRU_SEQ_PERF_EN
        , Run_cyc_out, Stall_cyc_out
`endif
    );

    modport slave (
        input  Mode_in, Wr_en_in, Wr_addr_in, Wr_data_in, Start_in,
               Last_idx_in, Loop_cnt_in, Stall_in, Abort_in,
        output En_out, Mode_out, Finish_out, CFG_out, Dvalid_out,
               Busy_out, Done_out, Idx_out, Iter_out
`ifdef LSRU_SEQ_PERF_EN
        , Run_cyc_out, Stall_cyc_out
`endif
    );
endinterface

// File: rtl/lsru_cfg_seq.sv
// rtl/lsru_cfg_seq.sv - LSRU config-word replay sequencer; LSRU_SEQ_PERF_EN adds run/stall cycle counters
// Context memory is host-written in IDLE and replayed entries 0..Last for Loop iterations.
module lsru_cfg_seq #(
    parameter int CFG_BITS  = 24,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int LOOP_BITS = 8
) (
    input  logic            CLK,
    input  logic            RST,
    lsru_cfg_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [AW-1:0]        IDX_ONE  = 1;
    localparam logic [LOOP_BITS-1:0] ITER_ONE = 1;

    state_t               state_q;
    logic [CFG_BITS-1:0]  mem_q [DEPTH];
    logic [AW-1:0]        idx_q;
    logic [AW-1:0]        last_q;
    logic [LOOP_BITS-1:0] iter_q;
    logic [LOOP_BITS-1:0] loop_q;
    logic [CFG_BITS-1:0]  cfg_q;
    logic                 en_q;
    logic                 mode_q;
    logic                 fin_q;
    logic                 dvalid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [LOOP_BITS-1:0] iter_d;
    logic [AW-1:0]        idx_d;
`ifdef LSRU_SEQ_PERF_EN
    logic [15:0]          run_cyc_q;
    logic [15:0]          stall_cyc_q;
`endif

    assign iter_d = iter_q + ITER_ONE;
    assign idx_d  = idx_q + IDX_ONE;

    // Context memory carries no reset; a same-edge write and Start lands before the first read.
    always_ff @(posedge CLK) begin
        if (bus.Wr_en_in && state_q == IDLE) begin
            mem_q[bus.Wr_addr_in] <= bus.Wr_data_in;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            iter_q   <= '0;
            loop_q   <= '0;
            cfg_q    <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            fin_q    <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef LSRU_SEQ_PERF_EN
            run_cyc_q   <= '0;
            stall_cyc_q <= '0;
`endif
        end else begin
            // LSRU registers its result one cycle after En, and Finish beats carry no data.
            dvalid_q <= en_q & ~fin_q;
            case (state_q)
                IDLE: begin
                    en_q   <= 1'b0;
                    fin_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.Start_in) begin
                        mode_q  <= bus.Mode_in;
                        last_q  <= bus.Last_idx_in;
                        loop_q  <= bus.Loop_cnt_in;
                        idx_q   <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.Loop_cnt_in == '0) ? FIN : RUN;
`ifdef LSRU_SEQ_PERF_EN
                        run_cyc_q   <= '0;
                        stall_cyc_q <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef LSRU_SEQ_PERF_EN
                    if (run_cyc_q != 16'hFFFF) begin
                        run_cyc_q <= run_cyc_q + 16'd1;
                    end
                    if (bus.Stall_in && !bus.Abort_in && stall_cyc_q != 16'hFFFF) begin
                        stall_cyc_q <= stall_cyc_q + 16'd1;
                    end
`endif
                    if (bus.Abort_in) begin
                        en_q    <= 1'b0;
                        state_q <= FIN;
                    end else if (bus.Stall_in) begin
                        en_q <= 1'b0;
                    end else begin
                        en_q  <= 1'b1;
                        cfg_q <= mem_q[idx_q];
                        if (idx_q == last_q) begin
                            idx_q  <= '0;
                            iter_q <= iter_d;
                            if (iter_d == loop_q) begin
                                state_q <= FIN;
                            end
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                FIN: begin
                    en_q    <= 1'b0;
                    fin_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.En_out     = en_q;
    assign bus.Mode_out   = mode_q;
    assign bus.Finish_out = fin_q;
    assign bus.CFG_out    = cfg_q;
    assign bus.Dvalid_out = dvalid_q;
    assign bus.Busy_out   = busy_q;
    assign bus.Done_out   = done_q;
    assign bus.Idx_out    = idx_q;
    assign bus.Iter_out   = iter_q;
`ifdef LSRU_SEQ_PERF_EN
    assign bus.Run_cyc_out   = run_cyc_q;
    assign bus.Stall_cyc_out = stall_cyc_q;
`endif
endmodule

// File: tb/tb_lsru_cfg_seq.sv
// tb/tb_lsru_cfg_seq.sv - randomized self-checking bench for lsru_cfg_seq against a beat-list model
module tb_lsru_cfg_seq;
    localparam int CFG_BITS  = 24;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int LOOP_BITS = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    lsru_cfg_seq_if #(.CFG_BITS(CFG_BITS), .AW(AW), .LOOP_BITS(LOOP_BITS)) bus ();

    lsru_cfg_seq #(.CFG_BITS(CFG_BITS), .DEPTH(DEPTH), .AW(AW), .LOOP_BITS(LOOP_BITS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int                  checks = 0;
    int                  errors = 0;
    logic [CFG_BITS-1:0] model_mem [DEPTH];
    logic [CFG_BITS-1:0] exp_cfg = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [CFG_BITS-1:0] d);
        bus.Wr_en_in   = 1'b1;
        bus.Wr_addr_in = AW'(a);
        bus.Wr_data_in = d;
        tick();
        bus.Wr_en_in = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.En_out, bus.Mode_out, bus.Finish_out, bus.Dvalid_out, bus.Busy_out, bus.Done_out}, 0);
        chk({tag, "_cfg"}, bus.CFG_out, 0);
        chk({tag, "_idx_iter"}, {bus.Idx_out, bus.Iter_out}, 0);
    endtask

    // Expected behaviour: the flat beat list mem[0..last] repeated loop times, one beat per unstalled cycle.
    task automatic run_seq(input logic mode, input int last, input int loop, input int stall_pct,
                           input logic [31:0] stall_mask, input int abort_after, input bit inject);
        logic [CFG_BITS-1:0] q[$];
        int  beats = 0, runcyc = 0, stallcyc = 0, cyc = 0;
        bit  prev_en = 0, done_run = 0, stall, abort;
        for (int it = 0; it < loop; it++)
            for (int i = 0; i <= last; i++) q.push_back(model_mem[i]);

        bus.Mode_in     = mode;
        bus.Last_idx_in = AW'(last);
        bus.Loop_cnt_in = LOOP_BITS'(loop);
        bus.Start_in    = 1'b1;
        tick();
        bus.Start_in = 1'b0;
        bus.Wr_en_in = 1'b0;
        chk("busy_at_start", bus.Busy_out, 1);
        chk("en_at_start", bus.En_out, 0);
        chk("mode_latched", bus.Mode_out, mode);
        chk("idx_iter_at_start", {bus.Idx_out, bus.Iter_out}, 0);

        if (loop != 0) begin
            while (!done_run && cyc < 2000) begin
                abort = (beats == abort_after);
                stall = (stall_pct > 0 && $urandom_range(99) < stall_pct) || (cyc < 32 && stall_mask[cyc]);
                bus.Abort_in = abort;
                bus.Stall_in = stall;
                if (inject && cyc == 1) begin
                    bus.Start_in   = 1'b1;
                    bus.Wr_en_in   = 1'b1;
                    bus.Wr_addr_in = '0;
                    bus.Wr_data_in = 24'hFFFFFF;
                end
                tick();
                bus.Abort_in = 1'b0;
                bus.Stall_in = 1'b0;
                bus.Start_in = 1'b0;
                bus.Wr_en_in = 1'b0;
                cyc++;
                runcyc++;
                chk("dvalid_lag", bus.Dvalid_out, prev_en);
                chk("busy_run", bus.Busy_out, 1);
                if (abort) begin
                    chk("en_abort", bus.En_out, 0);
                    done_run = 1;
                    prev_en  = 0;
                end else if (stall) begin
                    chk("en_stall", bus.En_out, 0);
                    chk("cfg_hold", bus.CFG_out, exp_cfg);
                    stallcyc++;
                    prev_en = 0;
                end else begin
                    chk("en_beat", bus.En_out, 1);
                    exp_cfg = q.pop_front();
                    chk("cfg_beat", bus.CFG_out, exp_cfg);
                    beats++;
                    chk("idx", bus.Idx_out, beats % (last + 1));
                    chk("iter", bus.Iter_out, beats / (last + 1));
                    prev_en = 1;
                    if (q.size() == 0) done_run = 1;
                end
            end
            if (!done_run) chk("run_timeout", 0, 1);
        end

        tick();
        chk("finish_pulse", {bus.Finish_out, bus.Done_out, bus.En_out, bus.Busy_out}, 4'b1100);
        chk("dvalid_fin", bus.Dvalid_out, prev_en);
        chk("iter_done", bus.Iter_out, beats / (last + 1));
        chk("cfg_after", bus.CFG_out, exp_cfg);
        tick();
        chk("finish_clear", {bus.Finish_out, bus.Done_out, bus.Dvalid_out, bus.Busy_out}, 0);
`ifdef LSRU_SEQ_PERF_EN
        chk("run_cyc", bus.Run_cyc_out, runcyc);
        chk("stall_cyc", bus.Stall_cyc_out, stallcyc);
`endif
    endtask

    initial begin
        int last, loop, total, ab;
        bus.Mode_in = 0; bus.Wr_en_in = 0; bus.Wr_addr_in = '0; bus.Wr_data_in = '0;
        bus.Start_in = 0; bus.Last_idx_in = '0; bus.Loop_cnt_in = '0;
        bus.Stall_in = 0; bus.Abort_in = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        #12;
        chk_all_zero("reset");
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr(i, '0);

        wr(0, 24'h200000); wr(1, 24'h040000); wr(2, 24'h000001);
        run_seq(1'b1, 2, 2, 0, 32'h0, -1, 0);
        run_seq(1'b0, 2, 2, 0, 32'b1010, -1, 0);
        run_seq(1'b1, 1, 0, 0, 32'h0, -1, 0);

        for (int i = 0; i < DEPTH; i++) wr(i, CFG_BITS'($urandom));
        run_seq(1'b1, 15, 1, 0, 32'h0, 5, 0);
        run_seq(1'b0, 3, 2, 0, 32'h0, -1, 1);
        run_seq(1'b0, 0, 1, 0, 32'h0, -1, 0);

        bus.Wr_en_in = 1'b1; bus.Wr_addr_in = '0; bus.Wr_data_in = 24'hA5A5A5;
        model_mem[0] = 24'hA5A5A5;
        run_seq(1'b1, 1, 1, 0, 32'h0, -1, 0);

        run_seq(1'b1, 0, 255, 0, 32'h0, -1, 0);

        bus.Mode_in = 1'b1; bus.Last_idx_in = 4'd3; bus.Loop_cnt_in = 8'd3; bus.Start_in = 1'b1;
        tick();
        bus.Start_in = 1'b0;
        repeat (4) tick();
        #2;
        RST = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_cfg = '0;
        @(negedge CLK);
        RST = 1'b1;
        run_seq(1'b0, 3, 1, 0, 32'h0, -1, 0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) wr($urandom_range(DEPTH - 1), CFG_BITS'($urandom));
            last  = $urandom_range(DEPTH - 1);
            loop  = $urandom_range(4);
            total = (last + 1) * loop;
            ab    = ($urandom_range(3) == 0 && total > 0) ? $urandom_range(total - 1) : -1;
            run_seq(1'($urandom), last, loop, $urandom_range(50), 32'h0, ab, 1'($urandom_range(1)) & (total > 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
